// File: rtl/key_debounce_pulse.sv
// Two-channel push-button conditioner: 2-flop synchronizer, debounce FSM and a
// single-cycle key pulse per accepted press, with a per-channel held level.

// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | button released and stable; waiting for a synchronized high
// ARMING     | sync high, counting stable-high cycles before accepting a press
// PRESSED    | press accepted (pulse already issued); waiting for sync low
// RELEASING  | sync low, counting stable-low cycles before accepting release
module key_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic key,
    output logic held
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s1_d;
    logic             s2_q;
    logic             s2_d;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             key_q;
    logic             key_d;
    logic             held_q;
    logic             held_d;
    logic             sync;
    logic             cnt_tc;

    assign sync   = s2_q;
    assign cnt_tc = (cnt_q == CNT_TC);

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync) begin
                    state_d = ST_ARMING;
                    cnt_d   = '0;
                end
            end
            ST_ARMING: begin
                if (!sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_tc) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    key_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync) begin
                    state_d = ST_RELEASING;
                    cnt_d   = '0;
                end
            end
            ST_RELEASING: begin
                // A high here is release bounce: fall back without a new pulse.
                if (sync) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_tc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            held_q  <= held_d;
        end
    end

    assign key  = key_q;
    assign held = held_q;

endmodule

module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Btn0Raw,
    input  logic       Btn1Raw,
    output logic       Key0,
    output logic       Key1,
    output logic [1:0] Held
);

    logic held0;
    logic held1;

    // Channels are independent; simultaneous pulses are left to the consumer.
    key_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_ch0 (
        .clk  (Clk),
        .reset(Reset),
        .raw  (Btn0Raw),
        .key  (Key0),
        .held (held0)
    );

    key_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_ch1 (
        .clk  (Clk),
        .reset(Reset),
        .raw  (Btn1Raw),
        .key  (Key1),
        .held (held1)
    );

    assign Held = {held1, held0};

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: run-length reference model checked every cycle,
// directed scenarios with literal pulse timing, then randomized bouncing input.
module tb_key_debounce_pulse;

    localparam int D = 16;

    logic       Clk;
    logic       Reset;
    logic       Btn0Raw;
    logic       Btn1Raw;
    logic       Key0;
    logic       Key1;
    logic [1:0] Held;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (20)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Btn0Raw(Btn0Raw),
        .Btn1Raw(Btn1Raw),
        .Key0   (Key0),
        .Key1   (Key1),
        .Held   (Held)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;
    int edge_num = 0;
    int k0_cnt = 0;
    int k1_cnt = 0;
    int k0_edge = -1;
    int k1_edge = -1;
    bit chk_en = 0;

    // Model: accepted level flips once sync has differed from it on D+1
    // consecutive edges; a flip to 1 is a key pulse.
    logic [1:0] m_s1  = '0;
    logic [1:0] m_s2  = '0;
    logic [1:0] m_lvl = '0;
    logic [1:0] m_key = '0;
    int         run[2] = '{0, 0};

    always @(posedge Clk) begin
        logic [1:0] raw;
        raw = {Btn1Raw, Btn0Raw};
        edge_num++;
        for (int ch = 0; ch < 2; ch++) begin
            if (Reset) begin
                m_s1[ch]  = 1'b0;
                m_s2[ch]  = 1'b0;
                m_lvl[ch] = 1'b0;
                m_key[ch] = 1'b0;
                run[ch]   = 0;
            end else begin
                m_key[ch] = 1'b0;
                if (m_s2[ch] != m_lvl[ch]) begin
                    run[ch]++;
                    if (run[ch] == D + 1) begin
                        m_lvl[ch] = m_s2[ch];
                        m_key[ch] = m_s2[ch];
                        run[ch]   = 0;
                    end
                end else begin
                    run[ch] = 0;
                end
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = raw[ch];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_num);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("key0", {31'd0, Key0}, {31'd0, m_key[0]});
            check("key1", {31'd0, Key1}, {31'd0, m_key[1]});
            check("held", {30'd0, Held}, {30'd0, m_lvl});
            if (Key0 === 1'b1) begin k0_cnt++; k0_edge = edge_num; end
            if (Key1 === 1'b1) begin k1_cnt++; k1_edge = edge_num; end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        int e0;
        int base0;
        int base1;
        int hold0;
        int hold1;

        Btn0Raw = 1'b0;
        Btn1Raw = 1'b0;
        Reset   = 1'b1;
        @(posedge Clk);
        #1 chk_en = 1;
        cyc(3);
        check("rst_key0", {31'd0, Key0}, 32'd0);
        check("rst_key1", {31'd0, Key1}, 32'd0);
        check("rst_held", {30'd0, Held}, 32'd0);
        Reset = 1'b0;
        cyc(5);

        // Clean press
        base0 = k0_cnt;
        Btn0Raw = 1'b1;
        e0 = edge_num + 1;
        cyc(40);
        check("press_cnt", k0_cnt - base0, 32'd1);
        check("press_edge", k0_edge, e0 + 18);
        check("press_key1", k1_cnt, 32'd0);
        check("press_held", {31'd0, Held[0]}, 32'd1);
        Btn0Raw = 1'b0;
        cyc(30);
        check("release_held", {30'd0, Held}, 32'd0);

        // Glitch rejection
        base0 = k0_cnt;
        Btn0Raw = 1'b1;
        cyc(10);
        Btn0Raw = 1'b0;
        cyc(30);
        check("glitch_cnt", k0_cnt - base0, 32'd0);
        check("glitch_held", {30'd0, Held}, 32'd0);

        // Press bounce on button 1
        base1 = k1_cnt;
        for (int i = 0; i < 10; i++) begin
            Btn1Raw = (i % 2 == 0);
            cyc(3);
        end
        check("bounce_none", k1_cnt - base1, 32'd0);
        Btn1Raw = 1'b1;
        e0 = edge_num + 1;
        cyc(30);
        check("bounce_cnt", k1_cnt - base1, 32'd1);
        check("bounce_edge", k1_edge, e0 + 18);
        Btn1Raw = 1'b0;
        cyc(30);

        // Release bounce and re-press
        base0 = k0_cnt;
        Btn0Raw = 1'b1;
        cyc(25);
        Btn0Raw = 1'b0;
        cyc(5);
        Btn0Raw = 1'b1;
        cyc(5);
        check("relbounce_one", k0_cnt - base0, 32'd1);
        Btn0Raw = 1'b0;
        cyc(30);
        Btn0Raw = 1'b1;
        e0 = edge_num + 1;
        cyc(25);
        check("repress_cnt", k0_cnt - base0, 32'd2);
        check("repress_edge", k0_edge, e0 + 18);
        Btn0Raw = 1'b0;
        cyc(30);

        // Simultaneous presses
        Btn0Raw = 1'b1;
        Btn1Raw = 1'b1;
        e0 = edge_num + 1;
        cyc(25);
        check("simul_edge0", k0_edge, e0 + 18);
        check("simul_edge1", k1_edge, e0 + 18);
        Btn0Raw = 1'b0;
        Btn1Raw = 1'b0;
        cyc(30);

        // Reset while channel 0 is arming with cnt = 10
        Btn0Raw = 1'b1;
        e0 = edge_num + 1;
        cyc(13);
        base0 = k0_cnt;
        Reset = 1'b1;
        cyc(1);
        check("midrst_key0", {31'd0, Key0}, 32'd0);
        check("midrst_key1", {31'd0, Key1}, 32'd0);
        check("midrst_held", {30'd0, Held}, 32'd0);
        Reset = 1'b0;
        e0 = edge_num + 1;
        cyc(30);
        check("midrst_cnt", k0_cnt - base0, 32'd1);
        check("midrst_edge", k0_edge, e0 + 18);
        Btn0Raw = 1'b0;
        cyc(30);

        // Randomized bouncing on both channels with occasional resets
        hold0 = 1;
        hold1 = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--hold0 == 0) begin
                Btn0Raw = ~Btn0Raw;
                hold0 = $urandom_range(1, 40);
            end
            if (--hold1 == 0) begin
                Btn1Raw = ~Btn1Raw;
                hold1 = $urandom_range(1, 40);
            end
            Reset = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        Reset = 1'b0;
        cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_debounce_pulse.md
# key_debounce_pulse

Front-end conditioning stage for the Lab 10 combination lock: takes the two raw push-button levels, synchronizes them to `Clk`, debounces them, and emits exactly one single-cycle `Key0`/`Key1` pulse per physical press. Its outputs drive the lock FSM's `Key0`/`Key1` inputs directly. A press never produces more than one pulse, no matter how long it is held.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required to accept a press or a release. Legal range is 2..2^`CNT_W`. Hardware builds override it, e.g. 1_000_000 at 100 MHz.
- `CNT_W`, default 20: width of each channel's debounce counter.
- `Clk`  input  1: system clock; all state updates on rising edge.
- `Reset`  input  1: reset is synchronous and active-high.
- `Btn0Raw`  input  1: raw, asynchronous, bouncing level of button 0 (1 = pressed).
- `Btn1Raw`  input  1: raw, asynchronous, bouncing level of button 1.
- `Key0`  output  1: registered one-cycle pulse per accepted press of button 0.
- `Key1`  output  1: registered one-cycle pulse per accepted press of button 1.
- `Held`  output  2: `Held[i]` = 1 while channel i is in PRESSED or RELEASING.

## Operation
- Per channel: a two-flop synchronizer (`s1` then `s2`) with both flops reset to 0. `sync` = `s2`.
- Two identical, fully independent channels. Each has a 4-state FSM and a `CNT_W`-bit counter `cnt`.
- IDLE state:
  - `sync`=1: go to ARMING, `cnt`<=0.
  - Otherwise: stay in IDLE.
- ARMING state:
  - `sync`=0: go to IDLE, `cnt`<=0. A glitch is discarded.
  - `sync`=1 and `cnt`==`DEBOUNCE_CYCLES`-1: go to PRESSED and set the Key register to 1.
  - `sync`=1 otherwise: `cnt`<=`cnt`+1.
- PRESSED state:
  - `sync`=1: stay in PRESSED; no repeat pulses.
  - `sync`=0: go to RELEASING, `cnt`<=0.
- RELEASING state:
  - `sync`=1: go back to PRESSED. This is release bounce, so no new pulse.
  - `sync`=0 and `cnt`==`DEBOUNCE_CYCLES`-1: go to IDLE.
  - `sync`=0 otherwise: `cnt`<=`cnt`+1.
- Key register is 1 only on the edge that makes the ARMING→PRESSED transition; it clears on every other edge. The pulse is therefore exactly one cycle wide.
- Counter never exceeds `DEBOUNCE_CYCLES`-1, so there is no wrap-around. It is zeroed on every state entry.
- Simultaneous presses: the channels do not arbitrate. `Key0` and `Key1` may pulse in the same cycle; the downstream FSM resolves this.
- Reset (any time, including mid-debounce):
  - Takes effect at the next edge.
  - Sync flops, counters and `Key0`/`Key1` go to 0. FSM goes to IDLE. `Held` goes to 2'b00.
  - A button held through reset release is treated as a new press and pulses after a full debounce.

## Timing
- Reset values: `Key0`=0, `Key1`=0, `Held`=2'b00.
- Press latency: `Btn0Raw` goes and stays high before edge 0.
  - `s1`=1 at edge 0, `s2`=1 at edge 1, ARMING entered at edge 2.
  - `cnt` reaches `DEBOUNCE_CYCLES`-1 at edge `DEBOUNCE_CYCLES`+1.
  - `Key0`=1 after edge `DEBOUNCE_CYCLES`+2 (edge 18 at default) and returns to 0 after the next edge.
- `Held[i]` rises on the same edge that pulses Key.
- Release latency: raw goes low before edge 0 → RELEASING at edge 2 → IDLE and `Held[i]`=0 at edge `DEBOUNCE_CYCLES`+2.
- Minimum accepted press: `DEBOUNCE_CYCLES`+1 stable synchronized cycles.
- Minimum accepted inter-press gap: `DEBOUNCE_CYCLES`+1 stable low synchronized cycles.

## Test plan
- Clean press:
  - Stimulus: `Btn0Raw` high before edge 0, held 40 cycles.
  - Required: `Key0` high for exactly the cycle after edge 18, and only then; `Held[0]`=1 from edge 18; `Key1` stays 0.
- Glitch rejection:
  - Stimulus: `Btn0Raw` high for 10 cycles, then low.
  - Required: `Key0` never asserts; `Held[0]` stays 0.
- Press bounce:
  - Stimulus: `Btn1Raw` toggles every 3 cycles for 30 cycles, then stays high.
  - Required: no pulse during the bounce; exactly one `Key1` pulse 18 edges after the final rising transition.
- Release bounce and re-press:
  - Stimulus: after an accepted press, low 5 cycles, high 5 cycles (no second pulse), then low 30 cycles, then high again.
  - Required: second `Key0` pulse 18 edges after the re-press.
- Simultaneous buttons:
  - Stimulus: both raw inputs rise before the same edge.
  - Required: `Key0` and `Key1` pulse in the same cycle (after edge 18).
- Reset mid-debounce:
  - Stimulus: assert `Reset` for 1 cycle while channel 0 is ARMING with `cnt`=10, raw held high throughout.
  - Required: all outputs 0 after that edge; `Key0` pulses after the 18th edge following `Reset` deassertion, once only.
